// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative BCD-to-binary converter.
// Consumes one latched BCD digit per cycle, most significant first, and
// accumulates acc = acc*10 + digit. Digit code 15 is a blank (suppressed
// leading zero); codes 10-14, a blank after a non-blank digit, or an
// accumulator that exceeds the result width all flag an error.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request a conversion; accepted in IDLE or DONE
//   bcd_in   DIGITS BCD codes, index 0 = least significant
//   busy     high while digits are being consumed
//   done     one-cycle pulse, bin_out/error valid
//   bin_out  binary result (0 when error), held until next done
//   error    result invalid, held with bin_out
module bcd_to_bin #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           bcd_in [0:DIGITS-1],
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] bin_out,
  output logic                 error
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Four spare bits hold acc*10 + 9 without wrapping, so overflow is exact.
  localparam int unsigned ACC_W = OUT_WIDTH + 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [3:0]           digit_q [0:DIGITS-1];
  logic [OUT_WIDTH-1:0] acc_q;
  logic                 seen_q;
  logic                 err_q;
  logic [IDX_W-1:0]     idx_q;

  logic                 accept_c;
  logic                 last_c;
  logic [3:0]           cur_digit_c;
  logic [ACC_W-1:0]     acc_wide_c;
  logic [OUT_WIDTH-1:0] acc_step_c;
  logic                 seen_step_c;
  logic                 err_step_c;

  // A new request is taken whenever no digits are in flight.
  assign accept_c    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_c      = (idx_q == '0);
  assign cur_digit_c = digit_q[idx_q];

  // acc*10 + d as shift-and-add at the widened width.
  assign acc_wide_c = (ACC_W'(acc_q) << 3) + (ACC_W'(acc_q) << 1) + ACC_W'(cur_digit_c);

  // One digit step: update accumulator, leading-blank tracking and error.
  always_comb begin
    acc_step_c  = acc_q;
    seen_step_c = seen_q;
    err_step_c  = err_q;
    if (cur_digit_c <= 4'd9) begin
      acc_step_c  = acc_wide_c[OUT_WIDTH-1:0];
      seen_step_c = 1'b1;
      if (acc_wide_c[ACC_W-1:OUT_WIDTH] != '0) begin
        err_step_c = 1'b1;
      end
    end else if (cur_digit_c == 4'd15) begin
      // Blank is only legal before the first real digit.
      if (seen_q) begin
        err_step_c = 1'b1;
      end
    end else begin
      err_step_c = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (last_c) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = start ? S_CONVERT : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_CONVERT);
      done  <= (state_next == S_DONE);
    end
  end

  // Digit latch, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        digit_q[i] <= 4'd0;
      end
      acc_q   <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      bin_out <= '0;
      error   <= 1'b0;
    end else if (accept_c) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        digit_q[i] <= bcd_in[i];
      end
      acc_q  <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= LAST_IDX;
    end else if (state == S_CONVERT) begin
      acc_q  <= acc_step_c;
      seen_q <= seen_step_c;
      err_q  <= err_step_c;
      if (last_c) begin
        bin_out <= err_step_c ? '0 : acc_step_c;
        error   <= err_step_c;
      end else begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: 4-digit and 5-digit instances,
// table-driven vectors plus handshake corner sequences and a round trip
// against a reference binary-to-BCD (leading blanks) function.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start5;
  logic [3:0]  bcd4 [0:3];
  logic [3:0]  bcd5 [0:4];
  logic        busy4, done4, err4;
  logic        busy5, done5, err5;
  logic [15:0] bin4, bin5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(4), .OUT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bcd_in(bcd4),
    .busy(busy4), .done(done4), .bin_out(bin4), .error(err4)
  );

  bcd_to_bin #(.DIGITS(5), .OUT_WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .bcd_in(bcd5),
    .busy(busy5), .done(done5), .bin_out(bin5), .error(err5)
  );

  typedef struct {
    logic [15:0] bcd;
    int          exp;
    bit          err;
  } vec4_t;

  typedef struct {
    logic [19:0] bcd;
    int          exp;
    bit          err;
  } vec5_t;

  vec4_t tbl4 [12];
  vec5_t tbl5 [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) bcd4[i] = v[4*i +: 4];
  endtask

  // Full 4-digit conversion with handshake timing checks.
  task automatic run4(input string name, input logic [15:0] v, input int exp, input bit experr);
    @(negedge clk);
    load4(v);
    start4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      chk({name, "_busy"}, 32'(busy4), 32'd1);
      chk({name, "_nodone"}, 32'(done4), 32'd0);
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(done4), 32'd1);
    chk({name, "_busy_lo"}, 32'(busy4), 32'd0);
    chk({name, "_bin"}, 32'(bin4), 32'(exp));
    chk({name, "_err"}, 32'(err4), 32'(experr));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(done4), 32'd0);
  endtask

  task automatic run5(input string name, input logic [19:0] v, input int exp, input bit experr);
    @(negedge clk);
    for (int i = 0; i < 5; i++) bcd5[i] = v[4*i +: 4];
    start5 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start5 = 1'b0;
      chk({name, "_busy"}, 32'(busy5), 32'd1);
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(done5), 32'd1);
    chk({name, "_bin"}, 32'(bin5), 32'(exp));
    chk({name, "_err"}, 32'(err5), 32'(experr));
  endtask

  // Reference display-path encoding: leading zeros shown as blank (15),
  // value 0 shown as a single 0.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    for (int i = 3; i > 0; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'd15;
    end
    return r;
  endfunction

  initial begin
    tbl4[0]  = '{16'hFF42, 42,   1'b0};
    tbl4[1]  = '{16'h1234, 1234, 1'b0};
    tbl4[2]  = '{16'h9999, 9999, 1'b0};
    tbl4[3]  = '{16'h0305, 305,  1'b0};
    tbl4[4]  = '{16'hFFFF, 0,    1'b0};
    tbl4[5]  = '{16'h1F34, 0,    1'b1};
    tbl4[6]  = '{16'h1C34, 0,    1'b1};
    tbl4[7]  = '{16'h5678, 5678, 1'b0};
    tbl4[8]  = '{16'h0000, 0,    1'b0};
    tbl4[9]  = '{16'hF0F5, 0,    1'b1};
    tbl4[10] = '{16'h000A, 0,    1'b1};
    tbl4[11] = '{16'hFFF9, 9,    1'b0};

    tbl5[0] = '{20'h70000, 0,     1'b1};
    tbl5[1] = '{20'h65535, 65535, 1'b0};
    tbl5[2] = '{20'h65536, 0,     1'b1};
    tbl5[3] = '{20'hFFFFF, 0,     1'b0};
    tbl5[4] = '{20'hF0100, 100,   1'b0};

    rst = 1'b1;
    start4 = 1'b0;
    start5 = 1'b0;
    load4(16'h0000);
    for (int i = 0; i < 5; i++) bcd5[i] = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_bin", 32'(bin4), 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_bin5", 32'(bin5), 32'd0);
    // Reset wins over start.
    start4 = 1'b1;
    @(negedge clk);
    chk("rst_over_start", 32'(busy4), 32'd0);
    start4 = 1'b0;
    rst = 1'b0;

    foreach (tbl4[i]) run4($sformatf("vec4_%0d", i), tbl4[i].bcd, tbl4[i].exp, tbl4[i].err);
    foreach (tbl5[i]) run5($sformatf("vec5_%0d", i), tbl5[i].bcd, tbl5[i].exp, tbl5[i].err);

    // start and bcd_in changed while busy: first latched value wins.
    @(negedge clk);
    load4(16'h1234);
    start4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      load4(16'h9999);
      start4 = (k < 4);
      chk("midstart_busy", 32'(busy4), 32'd1);
    end
    @(negedge clk);
    chk("midstart_done", 32'(done4), 32'd1);
    chk("midstart_bin", 32'(bin4), 32'd1234);

    // start in the DONE cycle of the previous conversion.
    load4(16'hFF42);
    start4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      chk("backtoback_busy", 32'(busy4), 32'd1);
      chk("backtoback_hold", 32'(bin4), 32'd1234);
    end
    @(negedge clk);
    chk("backtoback_done", 32'(done4), 32'd1);
    chk("backtoback_bin", 32'(bin4), 32'd42);
    @(negedge clk);
    chk("backtoback_idle", 32'(busy4), 32'd0);

    // Reset in the middle of a conversion aborts it.
    load4(16'h5678);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_bin", 32'(bin4), 32'd0);
    chk("abort_err", 32'(err4), 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      repeat (6) begin
        @(negedge clk);
        if (done4) seen_done++;
      end
      chk("abort_nodone", 32'(seen_done), 32'd0);
    end

    // Round trip through the display encoding.
    for (int v = 0; v <= 9999; v += 37) run4("roundtrip", to_bcd(v), v, 1'b0);
    run4("roundtrip", to_bcd(9999), 9999, 1'b0);
    for (int n = 0; n < 150; n++) begin
      int v;
      v = int'($urandom_range(9999, 0));
      run4("roundtrip", to_bcd(v), v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
